// File: rtl/thermal_plant_model.sv
// -----------------------------------------------------------------------------
// thermal_plant_model
//
// Synthesizable first-order room model. It sits on the far side of the
// heating/cooling controller interface and replaces a real temperature sensor
// in closed-loop simulation and on-board demos.
//
// While heating, the temperature rises by one step every HEAT_DIV enabled
// cycles. While cooling, it falls by one step every COOL_DIV enabled cycles.
// When idle, it moves one step toward AMBIENT every DRIFT_DIV enabled cycles.
//
// Ports:
//   i_clk          rising-edge clock
//   i_rst          synchronous active-high reset
//   i_enable       model advances only when 1
//   i_heating      heater command
//   i_cooling      cooler command
//   i_load         force temperature to i_load_value (ignores i_enable)
//   i_load_value   value written on load
//   o_temperature  registered temperature, 0..31
//   o_at_min       registered, temperature == 0
//   o_at_max       registered, temperature == 31
//   o_fault        registered, heating and cooling both set at last enabled edge
// -----------------------------------------------------------------------------
module thermal_plant_model #(
    parameter int unsigned TEMP_INIT = 20,
    parameter int unsigned AMBIENT   = 20,
    parameter int unsigned HEAT_DIV  = 4,
    parameter int unsigned COOL_DIV  = 4,
    parameter int unsigned DRIFT_DIV = 16,
    parameter int unsigned CNT_W     = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_enable,
    input  logic       i_heating,
    input  logic       i_cooling,
    input  logic       i_load,
    input  logic [4:0] i_load_value,
    output logic [4:0] o_temperature,
    output logic       o_at_min,
    output logic       o_at_max,
    output logic       o_fault
);

    typedef enum logic [1:0] {
        ModeDrift = 2'd0,
        ModeHeat  = 2'd1,
        ModeCool  = 2'd2,
        ModeFault = 2'd3
    } mode_e;

    localparam logic [4:0]       TempInit = 5'(TEMP_INIT);
    localparam logic [4:0]       Ambient  = 5'(AMBIENT);
    localparam logic [CNT_W-1:0] HeatDiv  = CNT_W'(HEAT_DIV);
    localparam logic [CNT_W-1:0] CoolDiv  = CNT_W'(COOL_DIV);
    localparam logic [CNT_W-1:0] DriftDiv = CNT_W'(DRIFT_DIV);

    logic [4:0]       r_temp;
    logic [CNT_W-1:0] r_cnt;
    mode_e            r_last_mode;
    logic             r_fault;
    logic             r_at_min;
    logic             r_at_max;

    mode_e            w_mode;
    logic [CNT_W-1:0] w_div;
    logic [CNT_W-1:0] w_run_len;
    logic [4:0]       w_step_temp;
    logic [4:0]       w_temp_d;
    logic [CNT_W-1:0] w_cnt_d;
    mode_e            w_last_mode_d;
    logic             w_fault_d;

    // Mode decode
    always_comb begin
        w_mode = ModeDrift;
        if (i_heating && i_cooling) begin
            w_mode = ModeFault;
        end else if (i_heating) begin
            w_mode = ModeHeat;
        end else if (i_cooling) begin
            w_mode = ModeCool;
        end
    end

    // Prescaler divide and saturating step value for the current mode
    always_comb begin
        w_div       = DriftDiv;
        w_step_temp = r_temp;
        unique case (w_mode)
            ModeHeat: begin
                w_div       = HeatDiv;
                w_step_temp = (r_temp == 5'd31) ? r_temp : r_temp + 5'd1;
            end
            ModeCool: begin
                w_div       = CoolDiv;
                w_step_temp = (r_temp == 5'd0) ? r_temp : r_temp - 5'd1;
            end
            ModeDrift: begin
                w_div = DriftDiv;
                if (r_temp < Ambient) begin
                    w_step_temp = r_temp + 5'd1;
                end else if (r_temp > Ambient) begin
                    w_step_temp = r_temp - 5'd1;
                end
            end
            ModeFault: begin
                w_div       = DriftDiv;
                w_step_temp = r_temp;
            end
        endcase
    end

    // A mode change starts a fresh run of length 1
    assign w_run_len = (w_mode != r_last_mode) ? CNT_W'(1) : r_cnt + CNT_W'(1);

    // Next state: load > disabled hold > enabled step
    always_comb begin
        w_temp_d      = r_temp;
        w_cnt_d       = r_cnt;
        w_last_mode_d = r_last_mode;
        w_fault_d     = r_fault;
        if (i_load) begin
            w_temp_d      = i_load_value;
            w_cnt_d       = '0;
            w_last_mode_d = w_mode;
            w_fault_d     = 1'b0;
        end else if (i_enable) begin
            w_last_mode_d = w_mode;
            if (w_mode == ModeFault) begin
                w_cnt_d   = '0;
                w_fault_d = 1'b1;
            end else begin
                w_fault_d = 1'b0;
                if (w_run_len == w_div) begin
                    w_temp_d = w_step_temp;
                    w_cnt_d  = '0;
                end else begin
                    w_cnt_d = w_run_len;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_temp      <= TempInit;
            r_cnt       <= '0;
            r_last_mode <= ModeDrift;
            r_fault     <= 1'b0;
            r_at_min    <= (TempInit == 5'd0);
            r_at_max    <= (TempInit == 5'd31);
        end else begin
            r_temp      <= w_temp_d;
            r_cnt       <= w_cnt_d;
            r_last_mode <= w_last_mode_d;
            r_fault     <= w_fault_d;
            // Flags come from next-state temperature so they track r_temp exactly
            r_at_min    <= (w_temp_d == 5'd0);
            r_at_max    <= (w_temp_d == 5'd31);
        end
    end

    assign o_temperature = r_temp;
    assign o_at_min      = r_at_min;
    assign o_at_max      = r_at_max;
    assign o_fault       = r_fault;

endmodule

// File: tb/tb_thermal_plant_model.sv
// -----------------------------------------------------------------------------
// tb_thermal_plant_model
//
// Bench for thermal_plant_model. A behavioural room model tracks the length of
// the current run of enabled cycles in one mode and steps whenever that length
// is a multiple of the mode's divide. The bench compares the model with the DUT
// on every falling edge. Directed scenarios pin both the DUT and the model to
// hand-computed literal values. A randomized phase follows them.
// -----------------------------------------------------------------------------
module tb_thermal_plant_model;

    localparam int TempInit = 20;
    localparam int Ambient  = 20;
    localparam int HeatDiv  = 4;
    localparam int CoolDiv  = 4;
    localparam int DriftDiv = 16;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       heating;
    logic       cooling;
    logic       load;
    logic [4:0] load_value;
    logic [4:0] temperature;
    logic       at_min;
    logic       at_max;
    logic       fault;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: mode codes 0 drift, 1 heat, 2 cool, 3 fault
    int m_temp  = 0;
    int m_last  = 0;
    int m_run   = 0;
    bit m_fault = 1'b0;
    bit m_valid = 1'b0;

    thermal_plant_model #(
        .TEMP_INIT(TempInit),
        .AMBIENT  (Ambient),
        .HEAT_DIV (HeatDiv),
        .COOL_DIV (CoolDiv),
        .DRIFT_DIV(DriftDiv),
        .CNT_W    (8)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_enable     (enable),
        .i_heating    (heating),
        .i_cooling    (cooling),
        .i_load       (load),
        .i_load_value (load_value),
        .o_temperature(temperature),
        .o_at_min     (at_min),
        .o_at_max     (at_max),
        .o_fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model update on every rising edge
    always @(posedge clk) begin
        int mode;
        int div;
        mode = (heating && cooling) ? 3 : heating ? 1 : cooling ? 2 : 0;
        if (rst) begin
            m_temp  = TempInit;
            m_last  = 0;
            m_run   = 0;
            m_fault = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid && load) begin
            m_temp  = int'(load_value);
            m_last  = mode;
            m_run   = 0;
            m_fault = 1'b0;
        end else if (m_valid && enable) begin
            if (mode == 3) begin
                m_fault = 1'b1;
                m_run   = 0;
            end else begin
                m_fault = 1'b0;
                m_run   = (mode == m_last) ? m_run + 1 : 1;
                div     = (mode == 1) ? HeatDiv : (mode == 2) ? CoolDiv : DriftDiv;
                if (m_run % div == 0) begin
                    if (mode == 1 && m_temp < 31) m_temp = m_temp + 1;
                    else if (mode == 2 && m_temp > 0) m_temp = m_temp - 1;
                    else if (mode == 0 && m_temp < Ambient) m_temp = m_temp + 1;
                    else if (mode == 0 && m_temp > Ambient) m_temp = m_temp - 1;
                end
            end
            m_last = mode;
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (m_valid) begin
            n_tests = n_tests + 4;
            if (int'(temperature) != m_temp) begin
                n_fail = n_fail + 1;
                $display("FAIL model_temp t=%0t: got %0d expected %0d", $time, temperature, m_temp);
            end
            if (at_min != (m_temp == 0)) begin
                n_fail = n_fail + 1;
                $display("FAIL model_at_min t=%0t: got %0b expected %0b", $time, at_min,
                         (m_temp == 0));
            end
            if (at_max != (m_temp == 31)) begin
                n_fail = n_fail + 1;
                $display("FAIL model_at_max t=%0t: got %0b expected %0b", $time, at_max,
                         (m_temp == 31));
            end
            if (fault != m_fault) begin
                n_fail = n_fail + 1;
                $display("FAIL model_fault t=%0t: got %0b expected %0b", $time, fault, m_fault);
            end
        end
    end

    task automatic drive(input bit r, input bit e, input bit h, input bit c, input bit l,
                         input int lv);
        rst        = r;
        enable     = e;
        heating    = h;
        cooling    = c;
        load       = l;
        load_value = 5'(lv);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pins both the DUT and the model to a hand-computed temperature
    task automatic lit_temp(input string name, input int exp);
        n_tests = n_tests + 2;
        if (int'(temperature) != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: dut temperature %0d, required %0d", name, temperature, exp);
        end
        if (m_temp != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: model temperature %0d, required %0d", name, m_temp, exp);
        end
    endtask

    task automatic lit_bit(input string name, input logic got, input bit exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0b, required %0b", name, got, exp);
        end
    endtask

    initial begin
        bit h;
        bit c;
        drive(1, 0, 0, 0, 0, 0);
        tick(2);
        lit_temp("reset_temp", 20);
        lit_bit("reset_at_min", at_min, 1'b0);
        lit_bit("reset_at_max", at_max, 1'b0);
        lit_bit("reset_fault", fault, 1'b0);
        drive(0, 0, 1, 0, 0, 0);
        tick(3);
        lit_temp("hold_disabled", 20);

        // Heat rate and saturation
        drive(0, 1, 1, 0, 0, 0);
        tick(3);
        lit_temp("heat_edge3", 20);
        tick(1);
        lit_temp("heat_edge4", 21);
        tick(4);
        lit_temp("heat_edge8", 22);
        tick(36);
        lit_temp("heat_edge44", 31);
        lit_bit("heat_at_max", at_max, 1'b1);
        tick(8);
        lit_temp("heat_saturated", 31);

        // Cool with count restart on mode change
        drive(0, 0, 0, 0, 1, 20);
        tick(1);
        lit_temp("load_20", 20);
        drive(0, 1, 1, 0, 0, 0);
        tick(3);
        lit_temp("heat_partial", 20);
        drive(0, 1, 0, 1, 0, 0);
        tick(3);
        lit_temp("cool_edge3", 20);
        tick(1);
        lit_temp("cool_edge4", 19);
        drive(0, 1, 0, 1, 1, 1);
        tick(1);
        lit_temp("load_1", 1);
        drive(0, 1, 0, 1, 0, 0);
        tick(8);
        lit_temp("cool_floor", 0);
        lit_bit("cool_at_min", at_min, 1'b1);

        // Drift toward ambient
        drive(0, 0, 0, 0, 1, 17);
        tick(1);
        lit_temp("load_17", 17);
        drive(0, 1, 0, 0, 0, 0);
        tick(15);
        lit_temp("drift_edge15", 17);
        tick(1);
        lit_temp("drift_edge16", 18);
        tick(16);
        lit_temp("drift_edge32", 19);
        tick(16);
        lit_temp("drift_edge48", 20);
        tick(16);
        lit_temp("drift_edge64", 20);

        // Fault, then a heat run split by disabled cycles
        drive(0, 1, 1, 1, 0, 0);
        tick(1);
        lit_bit("fault_set", fault, 1'b1);
        lit_temp("fault_frozen", 20);
        drive(0, 1, 1, 0, 0, 0);
        tick(2);
        lit_bit("fault_clear", fault, 1'b0);
        drive(0, 0, 1, 0, 0, 0);
        tick(5);
        drive(0, 1, 1, 0, 0, 0);
        tick(1);
        lit_temp("split_run_3", 20);
        tick(1);
        lit_temp("split_run_4", 21);

        // Mid-run reset discards the partial count
        tick(3);
        lit_temp("pre_reset", 21);
        drive(1, 1, 1, 0, 0, 0);
        tick(1);
        lit_temp("mid_reset", 20);
        drive(0, 1, 1, 0, 0, 0);
        tick(3);
        lit_temp("post_reset_3", 20);
        tick(1);
        lit_temp("post_reset_4", 21);

        // Randomized phase with sticky commands so runs reach their divides
        h = 1'b0;
        c = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                h = 1'($urandom_range(0, 1));
                c = 1'($urandom_range(0, 1));
            end
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), h, c,
                  ($urandom_range(0, 59) == 0), int'($urandom_range(0, 31)));
            tick(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/thermal_plant_model.md
Name: thermal_plant_model

Overview:
- Synthesizable first-order room model: the other end of the heating/cooling controller interface.
- Consumes the controller's heating/cooling commands and produces the 5-bit temperature word the controller reads.
- Used for closed-loop simulation and on-board demos, with no real sensor attached.
- Temperature rises while heating, falls while cooling, and drifts toward ambient when idle; all rates are set by cycle prescalers.

Parameters:
- TEMP_INIT, 20: temperature value after reset (0..31).
- AMBIENT, 20: drift target (0..31).
- HEAT_DIV, 4: consecutive enabled HEAT cycles per +1 step (>=1).
- COOL_DIV, 4: consecutive enabled COOL cycles per -1 step (>=1).
- DRIFT_DIV, 16: consecutive enabled DRIFT cycles per 1-step move toward AMBIENT (>=1).
- CNT_W, 8: prescaler counter width; every DIV must be < 2**CNT_W.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- rst, input, 1: synchronous, active-high reset.
- enable, input, 1: model advances only when 1.
- heating, input, 1: heater command from controller.
- cooling, input, 1: cooler command from controller.
- load, input, 1: force temperature to load_value.
- load_value, input, 5: value written on load.
- temperature, output, 5: registered model temperature, unsigned 0..31.
- at_min, output, 1: registered; temperature == 0.
- at_max, output, 1: registered; temperature == 31.
- fault, output, 1: registered; heating and cooling were both 1 at the last enabled edge.

Behaviour:
- Reset (rst=1 at edge), overriding everything:
  - temperature=TEMP_INIT, cnt=0, last_mode=DRIFT, fault=0.
  - at_min/at_max take values consistent with TEMP_INIT.
- Mode decode (combinational, each cycle):
  - FAULT = heating & cooling.
  - HEAT = heating & ~cooling.
  - COOL = cooling & ~heating.
  - DRIFT = neither.
- Priority at each edge: rst > load > enable=0 hold > mode step.
- load=1: temperature=load_value, cnt=0, last_mode=current mode, fault=0. Applies regardless of enable.
- enable=0, load=0: temperature, cnt, last_mode, fault all hold.
- Enabled edge, run-length rule:
  - run_len = 1 if mode != last_mode, else cnt+1.
  - last_mode <= mode.
  - If run_len == DIV(mode): apply step, cnt <= 0. Else cnt <= run_len.
  - First step therefore lands on the edge ending the DIV-th consecutive enabled cycle in that mode, then every DIV cycles after.
  - Any mode change restarts the count.
  - Disabled cycles neither count nor break the run.
- Steps:
  - HEAT: +1, saturating at 31.
  - COOL: -1, saturating at 0.
  - DRIFT: +1 if temperature < AMBIENT, -1 if > AMBIENT, none if equal. Prescaler still cycles when equal.
- FAULT: no step, cnt <= 0, fault <= 1. fault <= 0 on any enabled non-FAULT edge.
- Saturated step: the prescaler still resets to 0 and the value is unchanged (no wrap-around).
- at_min/at_max are registered from the next-state temperature, so they are always coherent with temperature in the same cycle.
- Latency: a command applied with enable=1 changes temperature exactly DIV edges later. Outputs never change combinationally from inputs.
- Mid-operation rst or load discards any partial prescaler count.

Test Plan:
- Reset/defaults: rst=1 for 2 cycles -> temperature=20, at_min=0, at_max=0, fault=0, held while enable=0.
- Heat rate: enable=1, heating=1 from 20 -> 21 on the 4th edge, 22 on the 8th; 44 edges -> 31, at_max=1, stays 31 for 8 more edges.
- Cool with restart: heating for 3 edges then cooling=1 (count restarts) -> still 20 after 3 cooling edges, 19 on the 4th; load_value=1 with load=1 then 8 cooling edges -> 0, at_min=1, no wrap.
- Drift: load 17, idle, enable=1 -> 18 at edge 16, 19 at 32, 20 at 48, still 20 at edge 64.
- Fault/enable: heating=cooling=1 -> fault=1 one edge later, temperature frozen, cnt cleared; heating only for 2 edges, enable=0 for 5, heating 2 more -> +1 on the 4th enabled edge.
- Reset mid-run: heating for 3 edges, rst=1 one edge, release -> 20, and the next +1 needs a full 4 enabled edges.
